// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - decode inputs and control/debug outputs of the multi-cycle main control FSM
//
// Signals:
//   opcode[5:0], funct[5:0]  IR fields, stable from S_DECODE until the next S_FETCH
//   dm_ready                 data memory done, sampled in S_MEM
//   pc_en, pc_select[1:0]    PC load strobe and source (00 pc+4, 01 branch, 10 jump, 11 register)
//   ir_wr, reg_wr, dm_wr     IR / GPR / data memory write strobes
//   reg_dst[1:0]             GPR write address (00 rt, 01 rd, 10 $31)
//   wd_sel[1:0]              GPR write data (00 ALU, 01 memory, 10 pc+4)
//   alu_src_b, alu_op[2:0]   ALU B source and operation
//   ext_op[1:0]              immediate extension (00 zero, 01 sign)
//   state[2:0]               current FSM state, for debug
//   instr_cnt, cycle_cnt     performance counters (zero unless MC_CTRL_PERF_EN)
// Modports: slave = controller side, master = environment driving the IR fields.
interface mc_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        dm_ready;
    logic        pc_en;
    logic [1:0]  pc_select;
    logic        ir_wr;
    logic        reg_wr;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        alu_src_b;
    logic [2:0]  alu_op;
    logic [1:0]  ext_op;
    logic        dm_wr;
    logic [2:0]  state;
    logic [31:0] instr_cnt;
    logic [31:0] cycle_cnt;

    modport slave (
        input  opcode, funct, dm_ready,
        output pc_en, pc_select, ir_wr, reg_wr, reg_dst, wd_sel,
               alu_src_b, alu_op, ext_op, dm_wr, state, instr_cnt, cycle_cnt
    );

    modport master (
        output opcode, funct, dm_ready,
        input  pc_en, pc_select, ir_wr, reg_wr, reg_dst, wd_sel,
               alu_src_b, alu_op, ext_op, dm_wr, state, instr_cnt, cycle_cnt
    );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - main control state machine of the multi-cycle MIPS core
//
// Ports:
//   clk    core clock, rising edge
//   reset  synchronous, active-high; all outputs except state read 0 while high
//   bus    mc_ctrl_if.slave: opcode/funct/dm_ready in, PC/IR/GPR/ALU/DM controls out
// Parameter RESET_STATE: encoding of S_FETCH, loaded on reset.
// Optional macro MC_CTRL_PERF_EN adds retired-instruction and cycle counters;
// without it instr_cnt/cycle_cnt are tied to 0.
module mc_ctrl #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic     clk,
    input  logic     reset,
    mc_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Plain vector so that illegal codes 5..7 are representable and recoverable.
    logic [2:0] state_q;
    state_t     next_state;

    logic       pc_en_c;
    logic [1:0] pc_select_c;
    logic       ir_wr_c;
    logic       reg_wr_c;
    logic [1:0] reg_dst_c;
    logic [1:0] wd_sel_c;
    logic       alu_src_b_c;
    logic [2:0] alu_op_c;
    logic [1:0] ext_op_c;
    logic       dm_wr_c;

    // Decode straight from the IR fields; the IR is stable for the whole instruction.
    logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal, is_alu;

    assign is_rtype = (bus.opcode == 6'b000000);
    assign is_addu  = is_rtype && (bus.funct == 6'b100001);
    assign is_subu  = is_rtype && (bus.funct == 6'b100011);
    assign is_jr    = is_rtype && (bus.funct == 6'b001000);
    assign is_ori   = (bus.opcode == 6'b001101);
    assign is_lui   = (bus.opcode == 6'b001111);
    assign is_lw    = (bus.opcode == 6'b100011);
    assign is_sw    = (bus.opcode == 6'b101011);
    assign is_beq   = (bus.opcode == 6'b000100);
    assign is_j     = (bus.opcode == 6'b000010);
    assign is_jal   = (bus.opcode == 6'b000011);
    assign is_alu   = is_addu | is_subu | is_ori | is_lui;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state  = S_FETCH;
        pc_en_c     = 1'b0;
        pc_select_c = 2'b00;
        ir_wr_c     = 1'b0;
        reg_wr_c    = 1'b0;
        reg_dst_c   = 2'b00;
        wd_sel_c    = 2'b00;
        alu_src_b_c = 1'b0;
        alu_op_c    = 3'b000;
        ext_op_c    = 2'b00;
        dm_wr_c     = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_wr_c    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                if (is_jal) begin
                    next_state = S_WB;
                end else if (is_alu || is_lw || is_sw || is_beq) begin
                    next_state = S_EXE;
                end else begin
                    // j, jr and every unsupported encoding retire here.
                    pc_en_c     = 1'b1;
                    pc_select_c = is_j ? 2'b10 : (is_jr ? 2'b11 : 2'b00);
                    next_state  = S_FETCH;
                end
            end
            S_EXE: begin
                alu_src_b_c = is_ori | is_lui | is_lw | is_sw;
                ext_op_c    = (is_lw | is_sw | is_beq) ? 2'b01 : 2'b00;
                if (is_subu || is_beq)  alu_op_c = 3'b001;
                else if (is_ori)        alu_op_c = 3'b010;
                else if (is_lui)        alu_op_c = 3'b011;
                else                    alu_op_c = 3'b000;
                if (is_beq) begin
                    pc_en_c     = 1'b1;
                    pc_select_c = 2'b01;
                    next_state  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                // Keep the address computation driven so the memory address
                // cannot drift while dm_ready is low.
                alu_src_b_c = 1'b1;
                ext_op_c    = 2'b01;
                alu_op_c    = 3'b000;
                dm_wr_c     = is_sw;
                if (!bus.dm_ready) begin
                    next_state = S_MEM;
                end else if (is_sw) begin
                    pc_en_c    = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_WB;
                end
            end
            S_WB: begin
                reg_wr_c    = 1'b1;
                pc_en_c     = 1'b1;
                reg_dst_c   = is_jal ? 2'b10 : ((is_addu | is_subu) ? 2'b01 : 2'b00);
                wd_sel_c    = is_jal ? 2'b10 : (is_lw ? 2'b01 : 2'b00);
                pc_select_c = is_jal ? 2'b10 : 2'b00;
                next_state  = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Reset masks every strobe so a write pending in the current state never lands.
    assign bus.pc_en     = reset ? 1'b0   : pc_en_c;
    assign bus.pc_select = reset ? 2'b00  : pc_select_c;
    assign bus.ir_wr     = reset ? 1'b0   : ir_wr_c;
    assign bus.reg_wr    = reset ? 1'b0   : reg_wr_c;
    assign bus.reg_dst   = reset ? 2'b00  : reg_dst_c;
    assign bus.wd_sel    = reset ? 2'b00  : wd_sel_c;
    assign bus.alu_src_b = reset ? 1'b0   : alu_src_b_c;
    assign bus.alu_op    = reset ? 3'b000 : alu_op_c;
    assign bus.ext_op    = reset ? 2'b00  : ext_op_c;
    assign bus.dm_wr     = reset ? 1'b0   : dm_wr_c;
    assign bus.state     = state_q;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] instr_q;
    logic [31:0] cycle_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= 32'd0;
            cycle_q <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (pc_en_c) begin
                instr_q <= instr_q + 32'd1;
            end
        end
    end

    assign bus.instr_cnt = instr_q;
    assign bus.cycle_cnt = cycle_q;
`else
    assign bus.instr_cnt = 32'd0;
    assign bus.cycle_cnt = 32'd0;
`endif

endmodule
